// File: rtl/regfile_param.sv
// regfile_param: parametrised register file, one write port, two read ports.
// Ports:
//   clock             - rising-edge clock for all storage
//   clr               - synchronous active-high clear of every register
//   ctrl_write_enable - write strobe
//   ctrl_write_reg    - write address
//   data_write        - write data
//   ctrl_read_reg_a/b - read addresses
//   data_read_a/b     - combinational read data (0 for out-of-range addresses)
// Optional macro REGFILE_BYPASS_EN adds write-to-read forwarding.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              clr,
    input  logic              ctrl_write_enable,
    input  logic [ADDR_W-1:0] ctrl_write_reg,
    input  logic [WIDTH-1:0]  data_write,
    input  logic [ADDR_W-1:0] ctrl_read_reg_a,
    input  logic [ADDR_W-1:0] ctrl_read_reg_b,
    output logic [WIDTH-1:0]  data_read_a,
    output logic [WIDTH-1:0]  data_read_b
);

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_reg
            if (ZERO_REG != 0 && g == 0) begin : g_zero
                // Hardwired zero: no storage, writes are dropped.
                assign regs[g] = '0;
            end else begin : g_store
                logic             we_g;
                logic [WIDTH-1:0] q;

                // One-hot decode; addresses >= NUM_REGS match nothing.
                assign we_g = ctrl_write_enable
                            && (ctrl_write_reg == ADDR_W'(g));

                always_ff @(posedge clock) begin
                    if (clr) begin
                        q <= '0;
                    end else if (we_g) begin
                        q <= data_write;
                    end
                end

                assign regs[g] = q;
            end
        end
    endgenerate

    // Read muxes default to 0 so out-of-range addresses read 0.
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ctrl_read_reg_a == ADDR_W'(i)) begin
                rd_a = regs[i];
            end
            if (ctrl_read_reg_b == ADDR_W'(i)) begin
                rd_b = regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_valid;
    logic wr_zero;
    logic byp_ok;

    assign wr_valid = int'(ctrl_write_reg) < NUM_REGS;
    assign wr_zero  = (ZERO_REG != 0) && (ctrl_write_reg == '0);
    // Forward only writes that will actually land in storage.
    assign byp_ok   = ctrl_write_enable && !clr && wr_valid && !wr_zero;

    assign data_read_a = (byp_ok && ctrl_write_reg == ctrl_read_reg_a)
                       ? data_write : rd_a;
    assign data_read_b = (byp_ok && ctrl_write_reg == ctrl_read_reg_b)
                       ? data_write : rd_b;
`else
    assign data_read_a = rd_a;
    assign data_read_b = rd_b;
`endif

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed self-checking bench for regfile_param.
// Covers the default build and a small WIDTH=8/NUM_REGS=12 variant.
module tb_regfile_param;

    logic        clock;
    logic        clr;

    logic        m_we;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdata;
    logic [4:0]  m_ra;
    logic [4:0]  m_rb;
    logic [31:0] m_da;
    logic [31:0] m_db;

    logic        p_we;
    logic [3:0]  p_wreg;
    logic [7:0]  p_wdata;
    logic [3:0]  p_ra;
    logic [3:0]  p_rb;
    logic [7:0]  p_da;
    logic [7:0]  p_db;

    int checks;
    int failures;

    regfile_param u_main (
        .clock             (clock),
        .clr               (clr),
        .ctrl_write_enable (m_we),
        .ctrl_write_reg    (m_wreg),
        .data_write        (m_wdata),
        .ctrl_read_reg_a   (m_ra),
        .ctrl_read_reg_b   (m_rb),
        .data_read_a       (m_da),
        .data_read_b       (m_db)
    );

    regfile_param #(
        .WIDTH    (8),
        .NUM_REGS (12),
        .ADDR_W   (4),
        .ZERO_REG (0)
    ) u_small (
        .clock             (clock),
        .clr               (clr),
        .ctrl_write_enable (p_we),
        .ctrl_write_reg    (p_wreg),
        .data_write        (p_wdata),
        .ctrl_read_reg_a   (p_ra),
        .ctrl_read_reg_b   (p_rb),
        .data_read_a       (p_da),
        .data_read_b       (p_db)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clr      = 1'b0;
        m_we     = 1'b0;
        m_wreg   = '0;
        m_wdata  = '0;
        m_ra     = '0;
        m_rb     = '0;
        p_we     = 1'b0;
        p_wreg   = '0;
        p_wdata  = '0;
        p_ra     = '0;
        p_rb     = '0;

        // 1: reset then sweep all addresses
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_ra = 5'(i);
            m_rb = 5'(31 - i);
            #1;
            check("rst_a", 64'(m_da), 64'd0);
            check("rst_b", 64'(m_db), 64'd0);
        end

        // 2: write 25+i to r1..r31
        for (int i = 1; i < 32; i++) begin
            m_we    = 1'b1;
            m_wreg  = 5'(i);
            m_wdata = 32'(25 + i);
            tick();
        end
        m_wreg  = 5'd0;
        m_wdata = 32'hDEAD_BEEF;
        m_ra    = 5'd0;
        #1;
        check("zero_during_wr", 64'(m_da), 64'd0);
        tick();
        m_we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            m_ra = 5'(i);
            m_rb = 5'(32 - i);
            #1;
            check("rd_pair_a", 64'(m_da), 64'(25 + i));
            check("rd_pair_b", 64'(m_db), 64'(57 - i));
        end
        m_ra = 5'd0;
        m_rb = 5'd0;
        #1;
        check("zero_a", 64'(m_da), 64'd0);
        check("zero_b", 64'(m_db), 64'd0);

        // 3: enable gating
        m_we    = 1'b1;
        m_wreg  = 5'd5;
        m_wdata = 32'd28;
        tick();
        m_we    = 1'b0;
        m_wdata = 32'd99;
        m_ra    = 5'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_r5", 64'(m_da), 64'd28);
        end
        m_rb = 5'd6;
        #1;
        check("hold_r6", 64'(m_db), 64'd31);

        // 4: clear beats simultaneous write; bypass off under clr
        clr     = 1'b1;
        m_we    = 1'b1;
        m_wreg  = 5'd7;
        m_wdata = 32'h1234;
        m_ra    = 5'd7;
        #1;
        check("clr_pre_r7", 64'(m_da), 64'd32);
        tick();
        clr  = 1'b0;
        m_we = 1'b0;
        #1;
        check("clr_r7", 64'(m_da), 64'd0);
        for (int i = 0; i < 32; i++) begin
            m_rb = 5'(i);
            #1;
            check("clr_all", 64'(m_db), 64'd0);
        end

        // 5: same-address read during write
        m_we    = 1'b1;
        m_wreg  = 5'd3;
        m_wdata = 32'h11;
        tick();
        m_wdata = 32'hA5A5_A5A5;
        m_ra    = 5'd3;
        m_rb    = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cyc_a", 64'(m_da), 64'hA5A5_A5A5);
`else
        check("same_cyc_a", 64'(m_da), 64'h11);
`endif
        check("same_cyc_b", 64'(m_db), 64'd0);
        tick();
        m_we = 1'b0;
        check("after_edge_a", 64'(m_da), 64'hA5A5_A5A5);

        // 6: small variant, ordinary r0 and out-of-range writes
        p_we    = 1'b1;
        p_wreg  = 4'd0;
        p_wdata = 8'hFF;
        tick();
        p_wreg  = 4'd11;
        p_wdata = 8'h3C;
        tick();
        p_wreg  = 4'd13;
        p_wdata = 8'h5A;
        p_ra    = 4'd13;
        #1;
        check("p_oor_during", 64'(p_da), 64'd0);
        tick();
        p_we = 1'b0;
        p_ra = 4'd0;
        p_rb = 4'd11;
        #1;
        check("p_r0", 64'(p_da), 64'hFF);
        check("p_r11", 64'(p_db), 64'h3C);
        p_ra = 4'd13;
        p_rb = 4'd1;
        #1;
        check("p_oor_rd", 64'(p_da), 64'd0);
        check("p_no_alias", 64'(p_db), 64'd0);
        p_rb = 4'd15;
        #1;
        check("p_oor_15", 64'(p_db), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised register file built from an array of clear-able, enable-gated registers.
- Provides one synchronous write port and two independent read ports.
- Serves as the architectural register file of the processor datapath and replaces fixed-width single registers instantiated ad hoc.
- Adds a hardwired-zero register option and an optional write-to-read bypass.

Parameters:
- WIDTH, 32, data width of each register in bits (1..64).
- NUM_REGS, 32, number of registers (2..64).
- ADDR_W, 5, address width; must satisfy 2**ADDR_W >= NUM_REGS.
- ZERO_REG, 1: if 1, register 0 always reads 0 and ignores writes; if 0, register 0 is ordinary storage.

Ports:
- clock  input  1  rising-edge clock for all storage.
- clr  input  1  synchronous active-high reset; clears every register on the rising edge of clock.
- ctrl_write_enable  input  1  write strobe, sampled on the rising edge.
- ctrl_write_reg  input  ADDR_W  write address.
- data_write  input  WIDTH  write data.
- ctrl_read_reg_a  input  ADDR_W  read address, port A.
- ctrl_read_reg_b  input  ADDR_W  read address, port B.
- data_read_a  output  WIDTH  read data, port A (combinational from storage).
- data_read_b  output  WIDTH  read data, port B (combinational from storage).

Behaviour:
- One clock; reset is synchronous and active-high (clock, clr).
- Reset:
  - On a rising edge with clr=1, all registers become 0.
  - clr has priority over a simultaneous write; the write is discarded.
  - After reset, data_read_a and data_read_b read 0 for every address.
  - Deasserting clr in the middle of a write sequence leaves no partial state: a register holds either 0 or a complete later write.
- Write:
  - On a rising edge with clr=0 and ctrl_write_enable=1, register[ctrl_write_reg] <= data_write.
  - All other registers hold their value.
  - Write latency is 1 cycle: the data is visible on read ports after the edge.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped and reads of address 0 return 0 regardless of stored contents.
- Read:
  - Purely combinational from stored state, with no internal read latency.
  - Ports A and B are independent and may address the same register.
- Out-of-range address (address >= NUM_REGS):
  - Writes are ignored; no aliasing and no wrap-around.
  - Reads return 0.
- Simultaneous write and read of the same address (base build, no bypass): the read returns the old value until the edge and the new value after it.
- Read outputs never depend on clr or ctrl_write_enable except through stored state (base build).
- Contents hold indefinitely while ctrl_write_enable=0 and clr=0.
- Decode:
  - Write decode is one-hot over NUM_REGS.
  - Read select is a WIDTH-wide multiplexer per port.
  - Implemented with generate loops. No latches; no tri-state buses.

Optional Feature:
- Macro name: REGFILE_BYPASS_EN.
- Defined:
  - When ctrl_write_enable=1, clr=0, the write address is valid and non-zero-reg, and it equals a read address, that port outputs data_write combinationally in the same cycle (write-before-read semantics).
  - Both ports bypass independently.
  - clr=1 suppresses bypass, and the port reads stored state.
- Undefined: no forwarding path; the behaviour is exactly as in the base build (read-before-write).

Test Plan:
1. Reset then read-back: assert clr for 1 cycle, then sweep ctrl_read_reg_a and ctrl_read_reg_b over 0..31 -> all reads 0.
2. Write/read all:
   - Write value 25+i to register i, for i=1..31, one per cycle.
   - Then read pairs (i, 32-i) -> data_read_a=25+i, data_read_b=57-i.
   - Register 0 reads 0 despite a write of 0xDEADBEEF.
3. Enable gating: write 28 to r5, then present data_write=99 to r5 with ctrl_write_enable=0 for 3 cycles -> r5 still reads 28.
4. Clear priority: in the same cycle, assert clr=1 with ctrl_write_enable=1, r7, 0x1234 -> after the edge, r7=0 and all other registers=0.
5. Same-address read during write (write 0xA5A5A5A5 to r3, which holds 0x11):
   - Without REGFILE_BYPASS_EN: data_read_a=0x11 before the edge and 0xA5A5A5A5 after.
   - With REGFILE_BYPASS_EN: data_read_a=0xA5A5A5A5 within the same cycle.
6. Parameter sweep (WIDTH=8, NUM_REGS=12, ADDR_W=4, ZERO_REG=0):
   - Write 0xFF to r0 -> r0 reads 0xFF.
   - Write to address 13 -> ignored; reading address 13 returns 0.
